// File: rtl/bsg_dfi_fifo_pkg.sv
// rtl/bsg_dfi_fifo_pkg.sv - shared command layout, opcodes, FSM states and constants for the DFI fifo responder
package bsg_dfi_fifo_pkg;

  localparam int burst_beats = 4;
  localparam int num_banks   = 8;
  localparam int cmd_width   = 26;

  localparam int cmd_odt_offset     = 0;
  localparam int cmd_reset_n_offset = 1;
  localparam int cmd_we_n_offset    = 2;
  localparam int cmd_cas_n_offset   = 3;
  localparam int cmd_ras_n_offset   = 4;
  localparam int cmd_cs_n_offset    = 5;
  localparam int cmd_cke_offset     = 6;
  localparam int cmd_addr_offset    = 7;
  localparam int cmd_bank_offset    = 23;

  typedef struct packed {
    logic [2:0]  bank;
    logic [15:0] addr;
    logic        cke;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic        reset_n;
    logic        odt;
  } dfi_cmd_s;

  typedef enum logic [2:0] {NOP, ACT, RD, WR, PRE, REF, MRS} dfi_op_e;

  typedef enum logic [2:0] {IDLE, WR_BEAT, RD_REQ, RD_RESP, RD_OUT} state_e;

  function automatic dfi_op_e decode_cmd(input logic [cmd_width-1:0] w);
    dfi_op_e op;
    op = NOP;
    if (!w[cmd_cs_n_offset]) begin
      case ({w[cmd_ras_n_offset], w[cmd_cas_n_offset], w[cmd_we_n_offset]})
        3'b011:  op = ACT;
        3'b101:  op = RD;
        3'b100:  op = WR;
        3'b010:  op = PRE;
        3'b001:  op = REF;
        3'b000:  op = MRS;
        default: op = NOP;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/bsg_dfi_bank_table.sv
// rtl/bsg_dfi_bank_table.sv - per-bank open flag and active row with combinational lookup
module bsg_dfi_bank_table
  import bsg_dfi_fifo_pkg::*;
#(
  parameter int row_width_p = 14
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [2:0]             bank,
  input  logic                   act_v,
  input  logic [row_width_p-1:0] act_row,
  input  logic                   pre_v,
  input  logic                   pre_all,
  output logic                   lookup_open,
  output logic [row_width_p-1:0] lookup_row
);

  logic [num_banks-1:0]   open_r;
  logic [row_width_p-1:0] row_r [num_banks];

  // Precharge only clears the open flag; the row is kept for unchecked builds.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      open_r <= '0;
      for (int i = 0; i < num_banks; i++) row_r[i] <= '0;
    end else if (act_v) begin
      open_r[bank] <= 1'b1;
      row_r[bank]  <= act_row;
    end else if (pre_v) begin
      if (pre_all) open_r <= '0;
      else         open_r[bank] <= 1'b0;
    end
  end

  assign lookup_open = open_r[bank];
  assign lookup_row  = row_r[bank];

endmodule

// File: rtl/bsg_dfi_fifo_responder.sv
// rtl/bsg_dfi_fifo_responder.sv - turns DFI command/write fifos into single-beat memory accesses and read beats
// Optional row checking: BSG_DFI_FIFO_RESPONDER_ROW_CHECK_EN
module bsg_dfi_fifo_responder
  import bsg_dfi_fifo_pkg::*;
#(
  parameter int dq_data_width_p = 16,
  parameter int row_width_p     = 14,
  parameter int col_width_p     = 10,
  localparam int dq_group_lp       = dq_data_width_p >> 3,
  localparam int mem_addr_width_lp = 3 + row_width_p + col_width_p - 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   cmd_v_i,
  input  logic [cmd_width-1:0]                   cmd_data_i,
  output logic                                   cmd_yumi_o,
  input  logic                                   wr_v_i,
  input  logic [2*dq_data_width_p+2*dq_group_lp-1:0] wr_data_i,
  output logic                                   wr_yumi_o,
  output logic                                   rd_v_o,
  output logic [2*dq_data_width_p-1:0]           rd_data_o,
  input  logic                                   rd_ready_i,
  output logic                                   mem_v_o,
  output logic                                   mem_w_o,
  output logic [mem_addr_width_lp-1:0]           mem_addr_o,
  output logic [2*dq_data_width_p-1:0]           mem_wdata_o,
  output logic [2*dq_group_lp-1:0]               mem_wmask_o,
  input  logic                                   mem_ready_i,
  input  logic                                   mem_rdata_v_i,
  input  logic [2*dq_data_width_p-1:0]           mem_rdata_i,
  output logic                                   error_o
);

`ifdef BSG_DFI_FIFO_RESPONDER_ROW_CHECK_EN
  localparam bit row_check_lp = 1'b1;
`else
  localparam bit row_check_lp = 1'b0;
`endif

  localparam int         data_width_lp = 2 * dq_data_width_p;
  localparam int         mask_width_lp = 2 * dq_group_lp;
  localparam logic [1:0] last_beat_lp  = 2'(burst_beats - 1);

  logic [2:0]               cmd_bank;
  logic [15:0]              cmd_addr;
  dfi_op_e                  cmd_op;
  state_e                   state_r, state_n;
  logic [1:0]               beat_r;
  logic [2:0]               burst_bank_r;
  logic [row_width_p-1:0]   burst_row_r;
  logic [col_width_p-4:0]   burst_col_r;
  logic                     burst_err_r;
  logic                     error_r;
  logic [data_width_lp-1:0] rd_data_r;
  logic                     bank_open;
  logic [row_width_p-1:0]   bank_row;
  logic                     act_v, pre_v, start_burst, bad_bank, beat_adv;
  logic                     unused_bits;

  assign cmd_bank    = cmd_data_i[cmd_bank_offset +: 3];
  assign cmd_addr    = cmd_data_i[cmd_addr_offset +: 16];
  assign cmd_op      = decode_cmd(cmd_data_i);
  assign unused_bits = ^{cmd_data_i[cmd_cke_offset], cmd_data_i[cmd_reset_n_offset],
                         cmd_data_i[cmd_odt_offset], cmd_addr};

  assign act_v       = cmd_yumi_o & (cmd_op == ACT);
  assign pre_v       = cmd_yumi_o & (cmd_op == PRE);
  assign start_burst = cmd_yumi_o & ((cmd_op == RD) | (cmd_op == WR));
  assign bad_bank    = row_check_lp & ~bank_open;

  bsg_dfi_bank_table #(.row_width_p(row_width_p)) bank_table (
    .clk        (clk_i),
    .reset_n    (reset_n_i),
    .bank       (cmd_bank),
    .act_v      (act_v),
    .act_row    (cmd_addr[row_width_p-1:0]),
    .pre_v      (pre_v),
    .pre_all    (cmd_addr[10]),
    .lookup_open(bank_open),
    .lookup_row (bank_row)
  );

  // All handshakes are gated by reset so nothing is consumed in the reset cycle.
  always_comb begin
    state_n    = state_r;
    cmd_yumi_o = 1'b0;
    wr_yumi_o  = 1'b0;
    mem_v_o    = 1'b0;
    mem_w_o    = 1'b0;
    rd_v_o     = 1'b0;
    beat_adv   = 1'b0;
    if (reset_n_i) begin
      unique case (state_r)
        IDLE: begin
          cmd_yumi_o = cmd_v_i;
          if (cmd_v_i && cmd_op == RD)      state_n = bad_bank ? RD_OUT : RD_REQ;
          else if (cmd_v_i && cmd_op == WR) state_n = WR_BEAT;
        end
        WR_BEAT: begin
          mem_v_o   = wr_v_i & ~burst_err_r;
          mem_w_o   = 1'b1;
          wr_yumi_o = wr_v_i & (mem_ready_i | burst_err_r);
          beat_adv  = wr_yumi_o;
          if (wr_yumi_o && beat_r == last_beat_lp) state_n = IDLE;
        end
        RD_REQ: begin
          mem_v_o = 1'b1;
          if (mem_ready_i) state_n = RD_RESP;
        end
        RD_RESP: begin
          if (mem_rdata_v_i) state_n = RD_OUT;
        end
        RD_OUT: begin
          rd_v_o   = 1'b1;
          beat_adv = rd_ready_i;
          if (rd_ready_i) begin
            if (beat_r == last_beat_lp) state_n = IDLE;
            else                        state_n = burst_err_r ? RD_OUT : RD_REQ;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r      <= IDLE;
      beat_r       <= '0;
      burst_bank_r <= '0;
      burst_row_r  <= '0;
      burst_col_r  <= '0;
      burst_err_r  <= 1'b0;
      rd_data_r    <= '0;
      error_r      <= 1'b0;
    end else begin
      state_r <= state_n;
      if (start_burst) begin
        burst_bank_r <= cmd_bank;
        burst_row_r  <= bank_row;
        burst_col_r  <= cmd_addr[col_width_p-1:3];
        beat_r       <= '0;
        burst_err_r  <= bad_bank;
        if (cmd_op == RD && bad_bank) rd_data_r <= '0;
      end else if (beat_adv) begin
        beat_r <= beat_r + 2'd1;
      end
      if (state_r == RD_RESP && mem_rdata_v_i) rd_data_r <= mem_rdata_i;
      if (row_check_lp && ((start_burst && bad_bank) || (act_v && bank_open))) error_r <= 1'b1;
    end
  end

  assign mem_addr_o  = {burst_bank_r, burst_row_r, burst_col_r, beat_r};
  assign mem_wdata_o = wr_data_i[mask_width_lp +: data_width_lp];
  assign mem_wmask_o = ~wr_data_i[mask_width_lp-1:0];
  assign rd_data_o   = rd_data_r;
  assign error_o     = error_r;

endmodule

// File: tb/tb_bsg_dfi_fifo_responder.sv
// tb/tb_bsg_dfi_fifo_responder.sv - directed self-checking bench for bsg_dfi_fifo_responder
module tb_bsg_dfi_fifo_responder;
  import bsg_dfi_fifo_pkg::*;

  localparam int dw_lp = 32;
  localparam int mw_lp = 4;
  localparam int aw_lp = 26;
  localparam logic [2:0] op_act = 3'b011, op_rd = 3'b101, op_wr = 3'b100,
                         op_pre = 3'b010, op_nop = 3'b111;

  logic             clk = 1'b0;
  logic             reset_n_i = 1'b0;
  logic             cmd_v_i = 1'b0;
  logic [25:0]      cmd_data_i = '0;
  logic             cmd_yumi_o;
  logic             wr_v_i = 1'b0;
  logic [dw_lp+mw_lp-1:0] wr_data_i = '0;
  logic             wr_yumi_o;
  logic             rd_v_o;
  logic [dw_lp-1:0] rd_data_o;
  logic             rd_ready_i = 1'b1;
  logic             mem_v_o, mem_w_o;
  logic [aw_lp-1:0] mem_addr_o;
  logic [dw_lp-1:0] mem_wdata_o;
  logic [mw_lp-1:0] mem_wmask_o;
  logic             mem_ready_i = 1'b1;
  logic             mem_rdata_v_i = 1'b0;
  logic [dw_lp-1:0] mem_rdata_i = '0;
  logic             error_o;

  int compared = 0;
  int mismatched = 0;

  bsg_dfi_fifo_responder #(.dq_data_width_p(16), .row_width_p(14), .col_width_p(10)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .cmd_v_i(cmd_v_i), .cmd_data_i(cmd_data_i), .cmd_yumi_o(cmd_yumi_o),
    .wr_v_i(wr_v_i), .wr_data_i(wr_data_i), .wr_yumi_o(wr_yumi_o),
    .rd_v_o(rd_v_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_v_i(mem_rdata_v_i), .mem_rdata_i(mem_rdata_i), .error_o(error_o)
  );

  always #5 clk = ~clk;

  // Backing memory and transaction logs
  logic [dw_lp-1:0] mem [logic [aw_lp-1:0]];
  logic [aw_lp-1:0] wr_addr_q[$];
  logic [dw_lp-1:0] wr_data_q[$];
  logic [mw_lp-1:0] wr_mask_q[$];
  logic [dw_lp-1:0] rd_q[$];
  int               rd_req_cnt = 0;
  int               mem_v_cycles = 0;
  logic             pend = 1'b0;
  logic [dw_lp-1:0] pend_data = '0;
  logic [dw_lp-1:0] merged;

  always @(negedge clk) begin
    if (mem_v_o) mem_v_cycles++;
    if (mem_v_o && mem_ready_i && reset_n_i) begin
      if (mem_w_o) begin
        merged = mem.exists(mem_addr_o) ? mem[mem_addr_o] : '0;
        for (int b = 0; b < mw_lp; b++)
          if (mem_wmask_o[b]) merged[8*b +: 8] = mem_wdata_o[8*b +: 8];
        mem[mem_addr_o] = merged;
        wr_addr_q.push_back(mem_addr_o);
        wr_data_q.push_back(mem_wdata_o);
        wr_mask_q.push_back(mem_wmask_o);
      end else begin
        rd_req_cnt++;
        pend = 1'b1;
        pend_data = mem.exists(mem_addr_o) ? mem[mem_addr_o] : '0;
      end
    end
    if (rd_v_o && rd_ready_i) rd_q.push_back(rd_data_o);
  end

  always @(posedge clk) begin
    #1;
    mem_rdata_v_i = pend;
    mem_rdata_i   = pend ? pend_data : '0;
    pend          = 1'b0;
  end

  function automatic logic [25:0] make_cmd(input logic [2:0] rcw, input logic [2:0] bank,
                                           input logic [15:0] addr);
    dfi_cmd_s c;
    c.bank = bank; c.addr = addr; c.cke = 1'b1; c.cs_n = 1'b0;
    c.ras_n = rcw[2]; c.cas_n = rcw[1]; c.we_n = rcw[0];
    c.reset_n = 1'b1; c.odt = 1'b0;
    return c;
  endfunction

  function automatic logic [aw_lp-1:0] exp_addr(input logic [2:0] b, input logic [13:0] r,
                                                input logic [9:0] c, input logic [1:0] beat);
    return {b, r, c[9:3], beat};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [25:0] w);
    int n;
    n = 0;
    cmd_v_i = 1'b1;
    cmd_data_i = w;
    @(negedge clk);
    while (!cmd_yumi_o && n < 50) begin @(negedge clk); n++; end
    if (!cmd_yumi_o) begin
      compared++; mismatched++;
      $display("FAIL cmd_pop_timeout yumi=%b want 1", cmd_yumi_o);
    end
    tick();
    cmd_v_i = 1'b0;
  endtask

  task automatic write_burst(input logic [dw_lp-1:0] base, input int masked_beat, input int beats);
    int n;
    logic [dw_lp-1:0] d;
    for (int i = 0; i < beats; i++) begin
      n = 0;
      d = base + i;
      wr_v_i = 1'b1;
      wr_data_i = {d, (i == masked_beat) ? 4'hF : 4'h0};
      @(negedge clk);
      while (!wr_yumi_o && n < 50) begin @(negedge clk); n++; end
      if (!wr_yumi_o) begin
        compared++; mismatched++;
        $display("FAIL wr_beat_timeout beat=%0d yumi=%b want 1", i, wr_yumi_o);
      end
      tick();
    end
    wr_v_i = 1'b0;
  endtask

  task automatic wait_rd_beats(input int want);
    int n;
    n = 0;
    while (rd_q.size() < want && n < 200) begin tick(); n++; end
    if (rd_q.size() < want) begin
      compared++; mismatched++;
      $display("FAIL rd_beat_timeout got %0d beats want %0d", rd_q.size(), want);
    end
  endtask

  task automatic apply_reset();
    reset_n_i = 1'b0; cmd_v_i = 1'b0; wr_v_i = 1'b0; rd_ready_i = 1'b1; mem_ready_i = 1'b1;
    tick(); tick();
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; cmd_v_i = 1'b1; cmd_data_i = make_cmd(op_nop, 3'd0, 16'h0);
    wr_v_i = 1'b1; rd_ready_i = 1'b1; mem_ready_i = 1'b1;
    tick(); tick();
    @(negedge clk);
    compared++;
    if ({cmd_yumi_o, wr_yumi_o, mem_v_o, rd_v_o} !== 4'b0) begin
      mismatched++;
      $display("FAIL reset_handshakes got %b want 0000", {cmd_yumi_o, wr_yumi_o, mem_v_o, rd_v_o});
    end
    tick();
    reset_n_i = 1'b1; cmd_v_i = 1'b0; wr_v_i = 1'b0;
    @(negedge clk);
    compared++;
    if (error_o !== 1'b0 || rd_data_o !== '0) begin
      mismatched++;
      $display("FAIL reset_state error=%b rd_data=%h want 0/0", error_o, rd_data_o);
    end
    compared++;
    if ({mem_v_o, rd_v_o, wr_yumi_o} !== 3'b0) begin
      mismatched++;
      $display("FAIL reset_idle_outputs got %b want 000", {mem_v_o, rd_v_o, wr_yumi_o});
    end
    tick();
  endtask

  task automatic test_write_read();
    wr_addr_q.delete(); wr_data_q.delete(); wr_mask_q.delete();
    send_cmd(make_cmd(op_act, 3'd2, 16'h0155));
    send_cmd(make_cmd(op_wr, 3'd2, 16'h0040));
    write_burst(32'hA0, -1, 4);
    compared++;
    if (wr_addr_q.size() != 4) begin
      mismatched++;
      $display("FAIL wr_count got %0d want 4", wr_addr_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (wr_addr_q[i] !== exp_addr(3'd2, 14'h155, 10'h040, 2'(i)) ||
          wr_data_q[i] !== 32'hA0 + i || wr_mask_q[i] !== 4'hF) begin
        mismatched++;
        $display("FAIL wr_beat%0d got addr=%h data=%h mask=%h want addr=%h data=%h mask=f", i,
                 wr_addr_q[i], wr_data_q[i], wr_mask_q[i],
                 exp_addr(3'd2, 14'h155, 10'h040, 2'(i)), 32'hA0 + i);
      end
    end
    rd_q.delete(); rd_req_cnt = 0; rd_ready_i = 1'b1;
    send_cmd(make_cmd(op_rd, 3'd2, 16'h0040));
    wait_rd_beats(4);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (rd_q[i] !== 32'hA0 + i) begin
        mismatched++;
        $display("FAIL rd_beat%0d got %h want %h", i, rd_q[i], 32'hA0 + i);
      end
    end
    compared++;
    if (rd_req_cnt != 4 || error_o !== 1'b0) begin
      mismatched++;
      $display("FAIL rd_reqs_error got reqs=%0d err=%b want 4/0", rd_req_cnt, error_o);
    end
  endtask

  task automatic test_write_mask();
    wr_addr_q.delete(); wr_data_q.delete(); wr_mask_q.delete();
    send_cmd(make_cmd(op_wr, 3'd2, 16'h0080));
    write_burst(32'hB0, 1, 4);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (wr_mask_q[i] !== ((i == 1) ? 4'h0 : 4'hF)) begin
        mismatched++;
        $display("FAIL wmask_beat%0d got %h want %h", i, wr_mask_q[i], (i == 1) ? 4'h0 : 4'hF);
      end
    end
  endtask

  task automatic test_backpressure();
    int c, stall, yumi_seen;
    rd_q.delete(); rd_req_cnt = 0; mem_ready_i = 1'b0; rd_ready_i = 1'b0;
    send_cmd(make_cmd(op_rd, 3'd2, 16'h0040));
    cmd_v_i = 1'b1; cmd_data_i = make_cmd(op_nop, 3'd0, 16'h0);
    c = 0; stall = 0; yumi_seen = 0;
    while (rd_q.size() < 4 && c < 200) begin
      @(negedge clk);
      if (cmd_yumi_o) yumi_seen++;
      if (rd_v_o && !rd_ready_i) stall++;
      tick();
      c++;
      mem_ready_i = (c >= 5);
      rd_ready_i  = (stall >= 3);
    end
    cmd_v_i = 1'b0; mem_ready_i = 1'b1; rd_ready_i = 1'b1;
    compared++;
    if (rd_q.size() != 4 || rd_req_cnt != 4) begin
      mismatched++;
      $display("FAIL bp_counts got beats=%0d reqs=%0d want 4/4", rd_q.size(), rd_req_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (rd_q[i] !== 32'hA0 + i) begin
        mismatched++;
        $display("FAIL bp_beat%0d got %h want %h", i, rd_q[i], 32'hA0 + i);
      end
    end
    compared++;
    if (yumi_seen != 0) begin
      mismatched++;
      $display("FAIL bp_cmd_yumi got %0d pops want 0", yumi_seen);
    end
    tick();
  endtask

  task automatic test_closed_bank();
    apply_reset();
    rd_q.delete(); rd_req_cnt = 0; mem_v_cycles = 0;
    send_cmd(make_cmd(op_rd, 3'd5, 16'h0000));
    wait_rd_beats(4);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (rd_q[i] !== '0) begin
        mismatched++;
        $display("FAIL closed_beat%0d got %h want 0", i, rd_q[i]);
      end
    end
`ifdef BSG_DFI_FIFO_RESPONDER_ROW_CHECK_EN
    compared++;
    if (error_o !== 1'b1 || mem_v_cycles != 0) begin
      mismatched++;
      $display("FAIL closed_rd got err=%b mem_v_cycles=%0d want 1/0", error_o, mem_v_cycles);
    end
`else
    compared++;
    if (error_o !== 1'b0 || rd_req_cnt != 4) begin
      mismatched++;
      $display("FAIL closed_rd got err=%b reqs=%0d want 0/4", error_o, rd_req_cnt);
    end
`endif
  endtask

  task automatic test_pre_all();
    apply_reset();
    send_cmd(make_cmd(op_act, 3'd0, 16'h0001));
    send_cmd(make_cmd(op_act, 3'd7, 16'h0002));
    send_cmd(make_cmd(op_pre, 3'd0, 16'h0400));
    wr_addr_q.delete(); wr_data_q.delete(); wr_mask_q.delete();
    send_cmd(make_cmd(op_wr, 3'd7, 16'h0000));
    write_burst(32'hD0, -1, 4);
`ifdef BSG_DFI_FIFO_RESPONDER_ROW_CHECK_EN
    compared++;
    if (error_o !== 1'b1 || wr_addr_q.size() != 0) begin
      mismatched++;
      $display("FAIL pre_all got err=%b writes=%0d want 1/0", error_o, wr_addr_q.size());
    end
`else
    compared++;
    if (error_o !== 1'b0 || wr_addr_q.size() != 4) begin
      mismatched++;
      $display("FAIL pre_all got err=%b writes=%0d want 0/4", error_o, wr_addr_q.size());
    end
`endif
  endtask

  task automatic test_double_act();
    apply_reset();
    send_cmd(make_cmd(op_act, 3'd3, 16'h0011));
    compared++;
    if (error_o !== 1'b0) begin
      mismatched++;
      $display("FAIL first_act got err=%b want 0", error_o);
    end
    send_cmd(make_cmd(op_act, 3'd3, 16'h0022));
    compared++;
`ifdef BSG_DFI_FIFO_RESPONDER_ROW_CHECK_EN
    if (error_o !== 1'b1) begin
      mismatched++;
      $display("FAIL double_act got err=%b want 1", error_o);
    end
`else
    if (error_o !== 1'b0) begin
      mismatched++;
      $display("FAIL double_act got err=%b want 0", error_o);
    end
`endif
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    send_cmd(make_cmd(op_act, 3'd1, 16'h0010));
    send_cmd(make_cmd(op_wr, 3'd1, 16'h0000));
    write_burst(32'hC0, -1, 2);
    reset_n_i = 1'b0; wr_v_i = 1'b1; wr_data_i = {32'hC2, 4'h0};
    cmd_v_i = 1'b1; cmd_data_i = make_cmd(op_nop, 3'd0, 16'h0);
    @(negedge clk);
    compared++;
    if ({cmd_yumi_o, wr_yumi_o, mem_v_o, rd_v_o} !== 4'b0) begin
      mismatched++;
      $display("FAIL midburst_reset_cycle got %b want 0000", {cmd_yumi_o, wr_yumi_o, mem_v_o, rd_v_o});
    end
    tick();
    reset_n_i = 1'b1; cmd_v_i = 1'b0;
    @(negedge clk);
    compared++;
    if ({cmd_yumi_o, wr_yumi_o, mem_v_o, rd_v_o, error_o} !== 5'b0 || rd_data_o !== '0) begin
      mismatched++;
      $display("FAIL midburst_idle got %b rd_data=%h want 00000/0",
               {cmd_yumi_o, wr_yumi_o, mem_v_o, rd_v_o, error_o}, rd_data_o);
    end
    tick();
    wr_v_i = 1'b0;
    rd_q.delete(); rd_req_cnt = 0;
    send_cmd(make_cmd(op_rd, 3'd1, 16'h0000));
    wait_rd_beats(4);
`ifdef BSG_DFI_FIFO_RESPONDER_ROW_CHECK_EN
    compared++;
    if (error_o !== 1'b1 || rd_req_cnt != 0) begin
      mismatched++;
      $display("FAIL midburst_bank_closed got err=%b reqs=%0d want 1/0", error_o, rd_req_cnt);
    end
`else
    compared++;
    if (error_o !== 1'b0 || rd_req_cnt != 4) begin
      mismatched++;
      $display("FAIL midburst_bank_closed got err=%b reqs=%0d want 0/4", error_o, rd_req_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_mask();
    test_backpressure();
    test_closed_bank();
    test_pre_all();
    test_double_act();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired compared=%0d", compared);
    $fatal(1, "watchdog");
  end

endmodule
